// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_ctrl
// Purpose  : Write-back controller for the single RV32I register-file write
//            port. ALU results (which cannot be stalled) take priority over
//            buffered load results. WAW order is preserved by killing older
//            loads to the same rd. A 32-bit pending-load scoreboard lets
//            decode stall on operands that a load still owes.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            alu_valid/rd/data     - ALU result, no backpressure
//            ld_valid/ready/rd/data- load result handshake
//            ld_issue/ld_issue_rd  - load issued by decode (sets pending)
//            rs1_addr/rs2_addr     - decode operand queries
//            busy_rs1/rs2/rd       - pending-load indications
//            wr_addr/wr_data/wr_en_- registered write port, enable active-low
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_ctrl #(
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic            ld_issue,
    input  logic [4:0]      ld_issue_rd,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            busy_rs1,
    output logic            busy_rs2,
    output logic            busy_rd,
    output logic [4:0]      wr_addr,
    output logic [XLEN-1:0] wr_data,
    output logic            wr_en_
);

    localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(LQ_DEPTH + 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(LQ_DEPTH);

    // Load buffer storage
    logic [4:0]          r_q_rd   [LQ_DEPTH];
    logic [XLEN-1:0]     r_q_data [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] r_q_kill;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [CNT_W-1:0]    r_count;

    logic [31:0]         r_pending;
    logic [31:0]         w_pend_next;

    logic                r_wr_en_n;
    logic [4:0]          r_wr_addr;
    logic [XLEN-1:0]     r_wr_data;

    logic                w_empty;
    logic                w_ld_acc;
    logic                w_alu_live;
    logic                w_pop;
    logic                w_bypass;
    logic                w_push;
    logic                w_push_kill;
    logic                w_sel_valid;
    logic [4:0]          w_sel_rd;
    logic [XLEN-1:0]     w_sel_data;
    logic                w_sel_kill;
    logic                w_do_write;

    assign w_empty    = (r_count == '0);
    assign ld_ready   = (r_count != C_FULL);
    assign w_ld_acc   = ld_valid && ld_ready;
    assign w_alu_live = alu_valid && (alu_rd != 5'd0);

    // ALU always wins; loads drain in FIFO order, bypassing only when empty.
    assign w_pop       = !alu_valid && !w_empty;
    assign w_bypass    = !alu_valid && w_empty && w_ld_acc;
    assign w_push      = w_ld_acc && !w_bypass;
    // An accepted load is older than a same-cycle ALU result to the same rd.
    assign w_push_kill = w_alu_live && (ld_rd == alu_rd);

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_rd    = 5'd0;
        w_sel_data  = '0;
        w_sel_kill  = 1'b0;
        if (alu_valid) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = alu_rd;
            w_sel_data  = alu_data;
        end else if (!w_empty) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = r_q_rd[r_rd_ptr];
            w_sel_data  = r_q_data[r_rd_ptr];
            w_sel_kill  = r_q_kill[r_rd_ptr];
        end else if (w_ld_acc) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = ld_rd;
            w_sel_data  = ld_data;
        end
    end

    assign w_do_write = w_sel_valid && (w_sel_rd != 5'd0) && !w_sel_kill;

    // Buffer payload carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_rd[r_wr_ptr]   <= ld_rd;
            r_q_data[r_wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q_kill <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Kill every buffered entry an in-flight ALU result supersedes.
            // Stale slots may be marked too; a push rewrites the kill bit.
            for (int i = 0; i < LQ_DEPTH; i++) begin
                if (w_alu_live && (r_q_rd[i] == alu_rd)) begin
                    r_q_kill[i] <= 1'b1;
                end
            end
            if (w_push) begin
                r_q_kill[r_wr_ptr] <= w_push_kill;
                r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Scoreboard: clear on any consumed load (popped or bypassed), then
    // apply the issue so that a same-cycle set wins.
    always_comb begin
        w_pend_next = r_pending;
        if (w_pop || w_bypass) begin
            w_pend_next[w_sel_rd] = 1'b0;
        end
        if (ld_issue && (ld_issue_rd != 5'd0)) begin
            w_pend_next[ld_issue_rd] = 1'b1;
        end
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pend_next;
        end
    end

    assign busy_rs1 = (rs1_addr != 5'd0) && r_pending[rs1_addr];
    assign busy_rs2 = (rs2_addr != 5'd0) && r_pending[rs2_addr];
    assign busy_rd  = (ld_issue_rd != 5'd0) && r_pending[ld_issue_rd];

    // Registered write port; address/data hold when no write is pulsed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en_n <= 1'b1;
            r_wr_addr <= 5'd0;
            r_wr_data <= '0;
        end else begin
            r_wr_en_n <= !w_do_write;
            if (w_do_write) begin
                r_wr_addr <= w_sel_rd;
                r_wr_data <= w_sel_data;
            end
        end
    end

    assign wr_en_  = r_wr_en_n;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_ctrl
// Purpose  : Self-checking bench for regfile_wb_ctrl. A queue-based reference
//            model is stepped on every rising edge and compared against the
//            DUT on every falling edge; directed scenarios add hand-computed
//            literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_ctrl;

    localparam int XLEN = 32;
    localparam int LQD  = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            ld_issue;
    logic [4:0]      ld_issue_rd;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            busy_rs1;
    logic            busy_rs2;
    logic            busy_rd;
    logic [4:0]      wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            wr_en_;

    int checks = 0;
    int errors = 0;

    regfile_wb_ctrl #(.XLEN(XLEN), .LQ_DEPTH(LQD)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .busy_rd(busy_rd),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en_(wr_en_)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          kill;
    } ent_t;

    ent_t        m_q[$];
    bit          m_pend[32];
    bit          m_valid = 1'b0;
    bit          m_en_n;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic model_step();
        ent_t        e;
        bit          acc;
        bit          sel;
        bit          skill;
        bit          clr;
        logic [4:0]  srd;
        logic [31:0] sdata;
        if (reset) begin
            m_q.delete();
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_en_n  = 1'b1;
            m_addr  = '0;
            m_data  = '0;
            m_valid = 1'b1;
            return;
        end
        acc = ld_valid && (m_q.size() < LQD);
        if (alu_valid && alu_rd != 0)
            foreach (m_q[i]) if (m_q[i].rd == alu_rd) m_q[i].kill = 1'b1;
        sel = 0; skill = 0; clr = 0; srd = '0; sdata = '0;
        if (alu_valid) begin
            sel = 1; srd = alu_rd; sdata = alu_data;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            sel = 1; srd = e.rd; sdata = e.data; skill = e.kill; clr = 1;
        end else if (acc) begin
            sel = 1; srd = ld_rd; sdata = ld_data; clr = 1;
            acc = 0;
        end
        if (acc) begin
            e.rd   = ld_rd;
            e.data = ld_data;
            e.kill = alu_valid && (alu_rd != 0) && (ld_rd == alu_rd);
            m_q.push_back(e);
        end
        if (clr) m_pend[srd] = 1'b0;
        if (ld_issue && ld_issue_rd != 0) m_pend[ld_issue_rd] = 1'b1;
        if (sel && srd != 0 && !skill) begin
            m_en_n = 1'b0; m_addr = srd; m_data = sdata;
        end else begin
            m_en_n = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("cmp_wr_en_", wr_en_, m_en_n);
            if (!m_en_n) begin
                chk("cmp_wr_addr", wr_addr, m_addr);
                chk("cmp_wr_data", wr_data, m_data);
            end
            chk("cmp_ld_ready", ld_ready, (m_q.size() < LQD));
            chk("cmp_busy_rs1", busy_rs1, (rs1_addr != 0) && m_pend[rs1_addr]);
            chk("cmp_busy_rs2", busy_rs2, (rs2_addr != 0) && m_pend[rs2_addr]);
            chk("cmp_busy_rd",  busy_rd,  (ld_issue_rd != 0) && m_pend[ld_issue_rd]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; ld_valid = 0; ld_issue = 0;
    endtask

    task automatic set_alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1; alu_rd = rd; alu_data = d;
    endtask

    task automatic set_ld(input logic [4:0] rd, input logic [31:0] d);
        ld_valid = 1; ld_rd = rd; ld_data = d;
    endtask

    initial begin
        reset = 1; alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0; ld_issue = 0; ld_issue_rd = 0;
        rs1_addr = 0; rs2_addr = 0;
        tick(); tick();
        chk("rst_wr_en_", wr_en_, 1);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_ld_ready", ld_ready, 1);
        reset = 0;

        // ALU write, then idle, then rd=0
        set_alu(5, 32'h1234); tick();
        chk("alu_wr_en_", wr_en_, 0);
        chk("alu_wr_addr", wr_addr, 5);
        chk("alu_wr_data", wr_data, 32'h1234);
        idle(); tick();
        chk("alu_one_cycle", wr_en_, 1);
        set_alu(0, 32'hDEAD); tick();
        chk("alu_rd0", wr_en_, 1);
        idle(); tick();

        // Buffer fill while ALU owns the port
        set_alu(1, 32'h101); set_ld(7, 32'h70); tick();
        set_alu(2, 32'h102); set_ld(8, 32'h80); tick();
        chk("fill_ready0", ld_ready, 0);
        set_alu(3, 32'h103); set_ld(10, 32'hA0); tick();
        chk("held_ready0", ld_ready, 0);
        set_alu(4, 32'h104); tick();
        alu_valid = 0; tick();
        chk("drain7_addr", wr_addr, 7);
        chk("drain7_data", wr_data, 32'h70);
        chk("drain7_en", wr_en_, 0);
        tick();
        chk("drain8_addr", wr_addr, 8);
        chk("drain8_data", wr_data, 32'h80);
        ld_valid = 0; tick();
        chk("drain10_addr", wr_addr, 10);
        chk("drain10_data", wr_data, 32'hA0);
        idle(); tick();

        // Scoreboard and bypass
        ld_issue = 1; ld_issue_rd = 9; rs1_addr = 9; tick();
        chk("issue_busy_rd", busy_rd, 1);
        chk("issue_busy_rs1", busy_rs1, 1);
        ld_issue = 0; set_ld(9, 32'hAA); tick();
        chk("bypass_en", wr_en_, 0);
        chk("bypass_addr", wr_addr, 9);
        chk("bypass_data", wr_data, 32'hAA);
        chk("bypass_busy_rs1", busy_rs1, 0);
        chk("bypass_busy_rd", busy_rd, 0);
        idle(); tick();

        // WAW kill
        ld_issue = 1; ld_issue_rd = 3; rs1_addr = 3; tick();
        ld_issue = 0; set_alu(6, 32'h66); set_ld(3, 32'h11); tick();
        ld_valid = 0; set_alu(3, 32'h22); tick();
        chk("waw_alu_addr", wr_addr, 3);
        chk("waw_alu_data", wr_data, 32'h22);
        chk("waw_busy_rs1", busy_rs1, 1);
        idle(); tick();
        chk("waw_killed_en", wr_en_, 1);
        chk("waw_cleared", busy_rs1, 0);
        tick();

        // Same-cycle set and clear of pending[4]
        ld_issue = 1; ld_issue_rd = 4; rs1_addr = 4; tick();
        ld_issue = 0; set_alu(1, 32'h1); set_ld(4, 32'h44); tick();
        idle(); ld_issue = 1; ld_issue_rd = 4; tick();
        chk("setwin_addr", wr_addr, 4);
        chk("setwin_data", wr_data, 32'h44);
        chk("setwin_busy", busy_rs1, 1);
        ld_issue = 0; tick();
        chk("setwin_hold", busy_rs1, 1);
        set_ld(4, 32'h45); tick();
        chk("setwin_clr", busy_rs1, 0);
        idle(); tick();

        // Reset mid-operation
        ld_issue = 1; ld_issue_rd = 11; tick();
        ld_issue_rd = 12; tick();
        ld_issue = 0; set_alu(1, 32'h1); set_ld(11, 32'hB1); tick();
        set_alu(2, 32'h2); set_ld(12, 32'hC2); tick();
        chk("prerst_full", ld_ready, 0);
        ld_valid = 0; set_alu(13, 32'hD); reset = 1;
        rs1_addr = 11; rs2_addr = 12; ld_issue_rd = 11; tick();
        chk("midrst_en", wr_en_, 1);
        chk("midrst_ready", ld_ready, 1);
        chk("midrst_busy_rs1", busy_rs1, 0);
        chk("midrst_busy_rs2", busy_rs2, 0);
        chk("midrst_busy_rd", busy_rd, 0);
        reset = 0; idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("postrst_nowrite", wr_en_, 1);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
